// File: rtl/cpu_clk_sequencer_if.sv
// Control/status bundle between the board-side controls and the 6502 clock sequencer.
// master drives the controls and watches status; slave is the sequencer itself.
interface cpu_clk_sequencer_if;
  logic        run;
  logic        step_btn;
  logic        bp_en;
  logic [15:0] bp_addr;
  logic [15:0] addr_bus;
  logic        cpu_clk;
  logic        cpu_res;
  logic [15:0] cycle_cnt;
  logic        halted;
  logic [2:0]  state;

  modport master (
    output run, step_btn, bp_en, bp_addr, addr_bus,
    input  cpu_clk, cpu_res, cycle_cnt, halted, state
  );

  modport slave (
    input  run, step_btn, bp_en, bp_addr, addr_bus,
    output cpu_clk, cpu_res, cycle_cnt, halted, state
  );
endinterface

// File: rtl/cpu_clk_sequencer.sv
// Derives the slow 6502 clock from CLK, sequences CPU reset at power-up, and runs,
// halts (cycle limit / breakpoint / run drop) and single-steps the core.
module cpu_clk_sequencer #(
  parameter int DIV         = 60000,
  parameter int RES_TICKS   = 3,
  parameter int START_TICKS = 6,
  parameter int MAX_CYCLES  = 264,
  parameter int DEBOUNCE    = 12000
) (
  input  logic                 CLK,
  input  logic                 R,
  cpu_clk_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    RESET_HOLD = 3'd0,
    WAIT_START = 3'd1,
    RUN        = 3'd2,
    HALT       = 3'd3,
    STEP       = 3'd4
  } state_e;

  localparam int              PW         = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int              DW         = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(DIV - 1);
  localparam logic [DW-1:0]   DEB_LAST   = DW'(DEBOUNCE - 1);
  localparam logic [7:0]      RES_T      = 8'(RES_TICKS);
  localparam logic [7:0]      START_T    = 8'(START_TICKS);
  localparam logic [15:0]     MAX_C      = 16'(MAX_CYCLES);

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [PW-1:0] presc_r;
  logic          tick_s;
  logic          sync1_r;
  logic          sync2_r;
  logic          btn_stable_r;
  logic [DW-1:0] deb_cnt_r;
  logic          deb_hit_s;
  logic          btn_rise_s;
  logic          step_req_r;
  logic          step_clr_s;
  logic          run_prev_r;
  logic          run_rise_s;

  state_e        state_r;
  state_e        state_nxt;
  logic          cpu_clk_r;
  logic          cpu_clk_nxt;
  logic          cpu_res_r;
  logic          cpu_res_nxt;
  logic [15:0]   cycle_cnt_r;
  logic [15:0]   cycle_cnt_nxt;
  logic          bp_skip_r;
  logic          bp_skip_nxt;
  logic [7:0]    tick_cnt_r;
  logic [7:0]    tick_cnt_nxt;
  logic          halted_r;
  logic          halted_nxt;

  logic [7:0]    tick_inc_s;
  logic [15:0]   cyc_inc_s;
  logic          lim_s;
  logic          stop_s;

  assign tick_s     = (presc_r == PRESC_LAST);
  assign tick_inc_s = sat_inc8(tick_cnt_r);
  assign cyc_inc_s  = sat_inc16(cycle_cnt_r);
  assign lim_s      = (MAX_C != 16'd0) && (cycle_cnt_r >= MAX_C);
  assign run_rise_s = bus.run && !run_prev_r;
  assign stop_s     = !bus.run || lim_s ||
                      (bus.bp_en && (bus.addr_bus == bus.bp_addr) && !bp_skip_r);
  assign deb_hit_s  = (sync2_r != btn_stable_r) && (deb_cnt_r == DEB_LAST);
  assign btn_rise_s = deb_hit_s && sync2_r;

  // Free-running prescaler; tick marks one cpu_clk half-period.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  // Button synchronizer and stability counter; btn_stable only follows a settled input.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      sync1_r      <= 1'b0;
      sync2_r      <= 1'b0;
      btn_stable_r <= 1'b0;
      deb_cnt_r    <= {DW{1'b0}};
    end else begin
      sync1_r <= bus.step_btn;
      sync2_r <= sync1_r;
      if (deb_hit_s) begin
        btn_stable_r <= sync2_r;
        deb_cnt_r    <= {DW{1'b0}};
      end else if (sync2_r != btn_stable_r) begin
        deb_cnt_r <= deb_cnt_r + DW'(1);
      end else begin
        deb_cnt_r <= {DW{1'b0}};
      end
    end
  end

  // Single pending step request; presses during free-run are thrown away.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      step_req_r <= 1'b0;
    end else if ((state_r == RUN) || step_clr_s) begin
      step_req_r <= 1'b0;
    end else if (btn_rise_s) begin
      step_req_r <= 1'b1;
    end else begin
      step_req_r <= step_req_r;
    end
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      state_r     <= RESET_HOLD;
      cpu_clk_r   <= 1'b0;
      cpu_res_r   <= 1'b1;
      cycle_cnt_r <= 16'd0;
      bp_skip_r   <= 1'b0;
      tick_cnt_r  <= 8'd0;
      halted_r    <= 1'b0;
      run_prev_r  <= 1'b0;
    end else begin
      state_r     <= state_nxt;
      cpu_clk_r   <= cpu_clk_nxt;
      cpu_res_r   <= cpu_res_nxt;
      cycle_cnt_r <= cycle_cnt_nxt;
      bp_skip_r   <= bp_skip_nxt;
      tick_cnt_r  <= tick_cnt_nxt;
      halted_r    <= halted_nxt;
      run_prev_r  <= bus.run;
    end
  end

  // Next-state logic; stop conditions are only looked at on a falling cpu_clk tick,
  // so the core never leaves RUN or STEP with its clock high.
  always_comb begin
    state_nxt     = state_r;
    cpu_clk_nxt   = cpu_clk_r;
    cpu_res_nxt   = cpu_res_r;
    cycle_cnt_nxt = cycle_cnt_r;
    bp_skip_nxt   = bp_skip_r;
    tick_cnt_nxt  = tick_cnt_r;
    step_clr_s    = 1'b0;
    case (state_r)
      RESET_HOLD: begin
        cpu_clk_nxt = 1'b0;
        if (tick_s) begin
          tick_cnt_nxt = tick_inc_s;
          if (tick_inc_s == RES_T) begin
            cpu_res_nxt = 1'b0;
            state_nxt   = WAIT_START;
          end else begin
            cpu_res_nxt = 1'b1;
          end
        end else begin
          cpu_res_nxt = 1'b1;
        end
      end
      WAIT_START: begin
        if (tick_s) begin
          tick_cnt_nxt = tick_inc_s;
          if (tick_inc_s == START_T) begin
            if (bus.run && !lim_s) begin
              state_nxt = RUN;
            end else begin
              state_nxt = HALT;
            end
          end else begin
            state_nxt = WAIT_START;
          end
        end else begin
          state_nxt = WAIT_START;
        end
      end
      RUN: begin
        if (tick_s) begin
          if (!cpu_clk_r) begin
            cpu_clk_nxt   = 1'b1;
            cycle_cnt_nxt = cyc_inc_s;
          end else begin
            cpu_clk_nxt = 1'b0;
            bp_skip_nxt = 1'b0;
            if (stop_s) begin
              state_nxt = HALT;
            end else begin
              state_nxt = RUN;
            end
          end
        end else begin
          state_nxt = RUN;
        end
      end
      HALT: begin
        cpu_clk_nxt = 1'b0;
        if (run_rise_s && !lim_s) begin
          state_nxt   = RUN;
          bp_skip_nxt = 1'b1;
        end else if (step_req_r) begin
          state_nxt  = STEP;
          step_clr_s = 1'b1;
        end else begin
          state_nxt = HALT;
        end
      end
      STEP: begin
        if (tick_s) begin
          if (!cpu_clk_r) begin
            cpu_clk_nxt   = 1'b1;
            cycle_cnt_nxt = cyc_inc_s;
          end else begin
            cpu_clk_nxt = 1'b0;
            state_nxt   = HALT;
          end
        end else begin
          state_nxt = STEP;
        end
      end
      default: begin
        state_nxt   = RESET_HOLD;
        cpu_clk_nxt = 1'b0;
        cpu_res_nxt = 1'b1;
      end
    endcase
    halted_nxt = (state_nxt == HALT);
  end

  assign bus.cpu_clk   = cpu_clk_r;
  assign bus.cpu_res   = cpu_res_r;
  assign bus.cycle_cnt = cycle_cnt_r;
  assign bus.halted    = halted_r;
  assign bus.state     = state_r;

endmodule

// File: tb/tb_cpu_clk_sequencer.sv
// Scoreboard bench: two sequencer instances (cycle-limited, and unlimited with breakpoint);
// expected output changes are queued ahead of stimulus and popped by per-instance monitors.
module tb_cpu_clk_sequencer;

  localparam logic [2:0] S_RH = 3'd0, S_WS = 3'd1, S_RUN = 3'd2, S_HALT = 3'd3, S_STEP = 3'd4;

  typedef struct packed {
    logic [2:0]  st;
    logic        ck;
    logic        rs;
    logic [15:0] cnt;
    logic        hl;
  } obs_t;

  typedef struct {
    int   delta;
    obs_t o;
  } rec_t;

  localparam obs_t RST_OBS = {3'd0, 1'b0, 1'b1, 16'd0, 1'b0};

  logic CLK = 1'b0;
  logic R_a = 1'b0;
  logic R_b = 1'b0;
  int   ea = 0;
  int   eb = 0;
  int   errors = 0;
  int   checks = 0;
  rec_t q_a[$];
  rec_t q_b[$];
  obs_t prev_o[2];
  int   last_e[2];
  int   nrec[2];

  always #5 CLK = ~CLK;

  cpu_clk_sequencer_if if_a();
  cpu_clk_sequencer_if if_b();

  cpu_clk_sequencer #(.DIV(4), .RES_TICKS(3), .START_TICKS(6), .MAX_CYCLES(5), .DEBOUNCE(8))
    dut_a (.CLK(CLK), .R(R_a), .bus(if_a));

  cpu_clk_sequencer #(.DIV(4), .RES_TICKS(3), .START_TICKS(6), .MAX_CYCLES(0), .DEBOUNCE(8))
    dut_b (.CLK(CLK), .R(R_b), .bus(if_b));

  always @(posedge CLK) begin
    ea <= R_a ? ea + 1 : 0;
    eb <= R_b ? eb + 1 : 0;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic push(input int w, input int d, input logic [2:0] st, input logic ck,
                      input logic rs, input logic [15:0] cnt, input logic hl);
    rec_t e;
    e.delta = d;
    e.o     = {st, ck, rs, cnt, hl};
    if (w == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic score(input int w, input logic rst_ok, input obs_t cur, input int en);
    rec_t e;
    int   sz;
    if (!rst_ok) begin
      prev_o[w] = RST_OBS;
      last_e[w] = 0;
    end else if (cur != prev_o[w]) begin
      checks++;
      sz = (w == 0) ? q_a.size() : q_b.size();
      if (sz == 0) begin
        errors++;
        $display("FAIL mon%0d unexpected change at edge %0d: st=%0d clk=%0b res=%0b cnt=%0d halt=%0b",
                 w, en, cur.st, cur.ck, cur.rs, cur.cnt, cur.hl);
      end else begin
        e = (w == 0) ? q_a.pop_front() : q_b.pop_front();
        nrec[w]++;
        if (cur != e.o || (e.delta >= 0 && (en - last_e[w]) != e.delta)) begin
          errors++;
          $display("FAIL mon%0d rec%0d: got st=%0d clk=%0b res=%0b cnt=%0d halt=%0b delta=%0d, expected st=%0d clk=%0b res=%0b cnt=%0d halt=%0b delta=%0d",
                   w, nrec[w], cur.st, cur.ck, cur.rs, cur.cnt, cur.hl, en - last_e[w],
                   e.o.st, e.o.ck, e.o.rs, e.o.cnt, e.o.hl, e.delta);
        end
      end
      prev_o[w] = cur;
      last_e[w] = en;
    end
  endtask

  initial begin
    nrec[0] = 0;
    forever begin
      @(negedge CLK);
      score(0, R_a, {if_a.state, if_a.cpu_clk, if_a.cpu_res, if_a.cycle_cnt, if_a.halted}, ea);
    end
  end

  initial begin
    nrec[1] = 0;
    forever begin
      @(negedge CLK);
      score(1, R_b, {if_b.state, if_b.cpu_clk, if_b.cpu_res, if_b.cycle_cnt, if_b.halted}, eb);
    end
  end

  task automatic wait_edge(input int w, input int n);
    while (((w == 0) ? ea : eb) < n) @(negedge CLK);
  endtask

  task automatic drain(input int w, input int max_cyc);
    int n = 0;
    while (((w == 0) ? q_a.size() : q_b.size()) != 0 && n < max_cyc) begin
      @(negedge CLK);
      n++;
    end
    chk($sformatf("drain%0d", w), 32'((w == 0) ? q_a.size() : q_b.size()), 32'd0);
  endtask

  // Power-up sequence up to the k_halt-th cycle, whose falling edge halts.
  task automatic push_powerup(input int w, input int k_halt);
    push(w, 12, S_WS, 1'b0, 1'b0, 16'd0, 1'b0);
    push(w, 12, S_RUN, 1'b0, 1'b0, 16'd0, 1'b0);
    for (int k = 1; k <= k_halt; k++) begin
      push(w, 4, S_RUN, 1'b1, 1'b0, 16'(k), 1'b0);
      if (k < k_halt) push(w, 4, S_RUN, 1'b0, 1'b0, 16'(k), 1'b0);
      else            push(w, 4, S_HALT, 1'b0, 1'b0, 16'(k), 1'b1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    if_a.run = 1'b1; if_a.step_btn = 1'b0; if_a.bp_en = 1'b0;
    if_a.bp_addr = 16'hFFFC; if_a.addr_bus = 16'h0000;
    if_b.run = 1'b1; if_b.step_btn = 1'b0; if_b.bp_en = 1'b1;
    if_b.bp_addr = 16'hFFFC; if_b.addr_bus = 16'h0000;
    repeat (3) @(negedge CLK);
    chk("a_rst_clk",   32'(if_a.cpu_clk),   32'd0);
    chk("a_rst_res",   32'(if_a.cpu_res),   32'd1);
    chk("a_rst_cnt",   32'(if_a.cycle_cnt), 32'd0);
    chk("a_rst_halt",  32'(if_a.halted),    32'd0);
    chk("a_rst_state", 32'(if_a.state),     32'(S_RH));

    // Instance A: power-up, then halt on the 5-cycle limit.
    push_powerup(0, 5);
    R_a = 1'b1;
    drain(0, 100);
    wait_edge(0, 66); if_a.run = 1'b0;
    wait_edge(0, 67); if_a.run = 1'b1;
    wait_edge(0, 90);
    chk("a_limit_state", 32'(if_a.state),     32'(S_HALT));
    chk("a_limit_cnt",   32'(if_a.cycle_cnt), 32'd5);
    // Step from a long press ignores the cycle limit.
    push(0, -1, S_STEP, 1'b0, 1'b0, 16'd5, 1'b0);
    push(0, -1, S_STEP, 1'b1, 1'b0, 16'd6, 1'b0);
    push(0, 4,  S_HALT, 1'b0, 1'b0, 16'd6, 1'b1);
    if_a.step_btn = 1'b1;
    wait_edge(0, 110); if_a.step_btn = 1'b0;
    drain(0, 40);
    wait_edge(0, 140); if_a.step_btn = 1'b1;
    wait_edge(0, 145); if_a.step_btn = 1'b0;
    wait_edge(0, 180);
    chk("a_glitch_state", 32'(if_a.state),     32'(S_HALT));
    chk("a_glitch_cnt",   32'(if_a.cycle_cnt), 32'd6);
    chk("a_glitch_clk",   32'(if_a.cpu_clk),   32'd0);

    // Instance B: breakpoint at 0xFFFC during cycle 3.
    push_powerup(1, 3);
    R_b = 1'b1;
    wait_edge(1, 45); if_b.addr_bus = 16'hFFFC;
    wait_edge(1, 50);
    chk("b_bp_cnt", 32'(if_b.cycle_cnt), 32'd3);
    push(1, 4, S_RUN,  1'b0, 1'b0, 16'd3, 1'b0);
    push(1, 4, S_RUN,  1'b1, 1'b0, 16'd4, 1'b0);
    push(1, 4, S_RUN,  1'b0, 1'b0, 16'd4, 1'b0);
    push(1, 4, S_RUN,  1'b1, 1'b0, 16'd5, 1'b0);
    push(1, 4, S_HALT, 1'b0, 1'b0, 16'd5, 1'b1);
    if_b.run = 1'b0;
    wait_edge(1, 51); if_b.run = 1'b1;
    wait_edge(1, 69); if_b.addr_bus = 16'h0000;

    // Free-run with a discarded step press, then drop run while cpu_clk is high.
    wait_edge(1, 70);
    push(1, 4, S_RUN, 1'b0, 1'b0, 16'd5, 1'b0);
    for (int k = 6; k <= 9; k++) begin
      push(1, 4, S_RUN, 1'b1, 1'b0, 16'(k), 1'b0);
      if (k < 9) push(1, 4, S_RUN,  1'b0, 1'b0, 16'(k), 1'b0);
      else       push(1, 4, S_HALT, 1'b0, 1'b0, 16'(k), 1'b1);
    end
    if_b.run = 1'b0;
    wait_edge(1, 71); if_b.run = 1'b1;
    wait_edge(1, 72); if_b.step_btn = 1'b1;
    wait_edge(1, 92); if_b.step_btn = 1'b0;
    wait_edge(1, 101);
    chk("b_drop_clk_high", 32'(if_b.cpu_clk), 32'd1);
    if_b.run = 1'b0;
    drain(1, 20);
    wait_edge(1, 140);
    chk("b_drop_state", 32'(if_b.state),     32'(S_HALT));
    chk("b_drop_cnt",   32'(if_b.cycle_cnt), 32'd9);
    chk("b_drop_clk",   32'(if_b.cpu_clk),   32'd0);

    // Asynchronous reset in the middle of a step's high phase.
    push(1, -1, S_STEP, 1'b0, 1'b0, 16'd9,  1'b0);
    push(1, -1, S_STEP, 1'b1, 1'b0, 16'd10, 1'b0);
    if_b.step_btn = 1'b1;
    drain(1, 40);
    chk("b_step_clk_high", 32'(if_b.cpu_clk), 32'd1);
    #1 R_b = 1'b0;
    #1;
    chk("b_arst_clk",   32'(if_b.cpu_clk),   32'd0);
    chk("b_arst_res",   32'(if_b.cpu_res),   32'd1);
    chk("b_arst_cnt",   32'(if_b.cycle_cnt), 32'd0);
    chk("b_arst_state", 32'(if_b.state),     32'(S_RH));
    chk("b_arst_halt",  32'(if_b.halted),    32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
